// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage and IF/ID pipeline register
//
// Holds the PC, issues one outstanding request at a time to instruction
// memory and presents fetched words to the decoder through IF/ID. A one-entry
// skid buffer catches a word that returns while decode is stalled. Redirects
// flush IF/ID and, if a request is still in flight, wait out its response.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   stall            decode cannot accept; IF/ID holds
//   redirect         taken branch/jump; flush and refetch at redirect_pc
//   redirect_pc      redirect target
//   imem_req         instruction memory request
//   imem_addr        request address, stable until imem_ready
//   imem_ready       response valid this cycle
//   imem_rdata       instruction word, valid with imem_ready
//   ifid_valid       IF/ID holds a real instruction
//   ifid_instr       instruction to decode (NOP_INSTR when invalid)
//   ifid_pc          address of ifid_instr
//   ifid_pc_plus2    ifid_pc + 2
//   halted           fetch stopped on a HALT opcode
module fetch_stage #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] NOP_INSTR = 16'h0800
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ready,
   input  logic [15:0] imem_rdata,
   output logic        ifid_valid,
   output logic [15:0] ifid_instr,
   output logic [15:0] ifid_pc,
   output logic [15:0] ifid_pc_plus2,
   output logic        halted
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_HOLD = 2'd1,
      S_DROP = 2'd2,
      S_HALT = 2'd3
   } state_t;

   state_t      r_state;
   logic [15:0] r_pc;
   logic [15:0] r_drop_addr;
   logic [15:0] r_skid_instr;
   logic [15:0] r_skid_pc;
   logic        r_ifid_valid;
   logic [15:0] r_ifid_instr;
   logic [15:0] r_ifid_pc;
   logic [15:0] r_ifid_pc_plus2;

   state_t      w_state_nxt;
   logic [15:0] w_pc_nxt;
   logic [15:0] w_drop_addr_nxt;
   logic [15:0] w_skid_instr_nxt;
   logic [15:0] w_skid_pc_nxt;
   logic        w_ifid_valid_nxt;
   logic [15:0] w_ifid_instr_nxt;
   logic [15:0] w_ifid_pc_nxt;
   logic [15:0] w_ifid_pc_plus2_nxt;

   logic        w_accept;
   logic        w_load;
   logic [15:0] w_load_instr;
   logic [15:0] w_load_pc;
   logic [15:0] w_pc_plus2;

   assign w_accept   = !r_ifid_valid || !stall;
   assign w_pc_plus2 = r_pc + 16'd2;

   always_comb begin
      w_state_nxt         = r_state;
      w_pc_nxt            = r_pc;
      w_drop_addr_nxt     = r_drop_addr;
      w_skid_instr_nxt    = r_skid_instr;
      w_skid_pc_nxt       = r_skid_pc;
      w_ifid_valid_nxt    = r_ifid_valid;
      w_ifid_instr_nxt    = r_ifid_instr;
      w_ifid_pc_nxt       = r_ifid_pc;
      w_ifid_pc_plus2_nxt = r_ifid_pc_plus2;
      w_load              = 1'b0;
      w_load_instr        = NOP_INSTR;
      w_load_pc           = 16'h0000;

      case (r_state)
         S_REQ: begin
            if (imem_ready) begin
               w_pc_nxt = w_pc_plus2;
               if (w_accept) begin
                  w_load       = 1'b1;
                  w_load_instr = imem_rdata;
                  w_load_pc    = r_pc;
                  w_state_nxt  = (imem_rdata[15:11] == 5'b00000) ? S_HALT : S_REQ;
               end else begin
                  // Decode is stalled on a valid entry: park the word.
                  w_skid_instr_nxt = imem_rdata;
                  w_skid_pc_nxt    = r_pc;
                  w_state_nxt      = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (!stall) begin
               w_load       = 1'b1;
               w_load_instr = r_skid_instr;
               w_load_pc    = r_skid_pc;
               w_state_nxt  = (r_skid_instr[15:11] == 5'b00000) ? S_HALT : S_REQ;
            end
         end
         S_DROP: begin
            // Response to the abandoned request is consumed and thrown away.
            if (imem_ready) begin
               w_state_nxt = S_REQ;
            end
         end
         S_HALT: begin
            w_state_nxt = S_HALT;
         end
         default: begin
            w_state_nxt = S_REQ;
         end
      endcase

      if (w_load) begin
         w_ifid_valid_nxt    = 1'b1;
         w_ifid_instr_nxt    = w_load_instr;
         w_ifid_pc_nxt       = w_load_pc;
         w_ifid_pc_plus2_nxt = w_load_pc + 16'd2;
      end else if (r_ifid_valid && !stall) begin
         w_ifid_valid_nxt = 1'b0;
         w_ifid_instr_nxt = NOP_INSTR;
      end

      // Redirect wins over everything computed above.
      if (redirect) begin
         w_pc_nxt         = redirect_pc;
         w_ifid_valid_nxt = 1'b0;
         w_ifid_instr_nxt = NOP_INSTR;
         w_skid_instr_nxt = NOP_INSTR;
         w_skid_pc_nxt    = 16'h0000;
         case (r_state)
            S_REQ: begin
               if (imem_ready) begin
                  w_state_nxt = S_REQ;
               end else begin
                  // Memory still owes a response for r_pc; keep asking for it.
                  w_drop_addr_nxt = r_pc;
                  w_state_nxt     = S_DROP;
               end
            end
            S_DROP:  w_state_nxt = S_DROP;
            default: w_state_nxt = S_REQ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= S_REQ;
         r_pc            <= RESET_PC;
         r_drop_addr     <= 16'h0000;
         r_skid_instr    <= NOP_INSTR;
         r_skid_pc       <= 16'h0000;
         r_ifid_valid    <= 1'b0;
         r_ifid_instr    <= NOP_INSTR;
         r_ifid_pc       <= 16'h0000;
         r_ifid_pc_plus2 <= 16'h0000;
      end else begin
         r_state         <= w_state_nxt;
         r_pc            <= w_pc_nxt;
         r_drop_addr     <= w_drop_addr_nxt;
         r_skid_instr    <= w_skid_instr_nxt;
         r_skid_pc       <= w_skid_pc_nxt;
         r_ifid_valid    <= w_ifid_valid_nxt;
         r_ifid_instr    <= w_ifid_instr_nxt;
         r_ifid_pc       <= w_ifid_pc_nxt;
         r_ifid_pc_plus2 <= w_ifid_pc_plus2_nxt;
      end
   end

   assign imem_req      = (r_state == S_REQ) || (r_state == S_DROP);
   assign imem_addr     = (r_state == S_REQ)  ? r_pc :
                          (r_state == S_DROP) ? r_drop_addr : 16'h0000;
   assign ifid_valid    = r_ifid_valid;
   assign ifid_instr    = r_ifid_instr;
   assign ifid_pc       = r_ifid_pc;
   assign ifid_pc_plus2 = r_ifid_pc_plus2;
   assign halted        = (r_state == S_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
module tb_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ready;
   logic [15:0] imem_rdata;
   logic        ifid_valid;
   logic [15:0] ifid_instr;
   logic [15:0] ifid_pc;
   logic [15:0] ifid_pc_plus2;
   logic        halted;

   fetch_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rdata    (imem_rdata),
      .ifid_valid    (ifid_valid),
      .ifid_instr    (ifid_instr),
      .ifid_pc       (ifid_pc),
      .ifid_pc_plus2 (ifid_pc_plus2),
      .halted        (halted)
   );

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc;
      logic [15:0] pc2;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   // Memory model controls
   logic mem_en  = 1'b0;
   logic halt_en = 1'b0;
   int   lat     = 1;
   int   cnt     = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      if (halt_en && a == 16'h0020) return 16'h0000;
      if (a == 16'hFFFE) return 16'h4800;
      return 16'h4000 | (a >> 1);
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
      end
   endtask

   // Memory: answers lat cycles after the request first appears.
   always @(posedge clk) begin
      if (!rst_n || !mem_en || !imem_req || imem_ready) cnt = 0;
      else cnt = cnt + 1;
   end

   always @(negedge clk) begin
      imem_ready = rst_n && mem_en && imem_req && (cnt >= lat - 1);
      imem_rdata = imem_ready ? mem_word(imem_addr) : 16'hDEAD;
   end

   // Monitor: compares each instruction as decode consumes it.
   always @(negedge clk) begin
      if (rst_n && ifid_valid && !stall && !redirect) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_ifid_pc", ifid_pc, 16'hFFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_instr", ifid_instr, e.instr);
            chk("sb_pc", ifid_pc, e.pc);
            chk("sb_pc_plus2", ifid_pc_plus2, e.pc2);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] i, input logic [15:0] p);
      exp_t e;
      e.instr = i;
      e.pc    = p;
      e.pc2   = p + 16'd2;
      exp_q.push_back(e);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_valid"}, {15'd0, ifid_valid}, 16'd0);
      chk({tag, "_instr"}, ifid_instr, 16'h0800);
      chk({tag, "_pc"}, ifid_pc, 16'h0000);
      chk({tag, "_pc2"}, ifid_pc_plus2, 16'h0000);
      chk({tag, "_halted"}, {15'd0, halted}, 16'd0);
      chk({tag, "_addr"}, imem_addr, 16'h0000);
   endtask

   initial begin
      bit seen;
      rst_n       = 1'b0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 16'h0000;
      imem_ready  = 1'b0;
      imem_rdata  = 16'h0000;

      // Reset state
      tick();
      check_reset_vals("rst");
      chk("rst_req", {15'd0, imem_req}, 16'd1);

      // Back-to-back fetch with a 1-cycle memory
      push(16'h4000, 16'h0000);
      push(16'h4001, 16'h0002);
      push(16'h4002, 16'h0004);
      rst_n  = 1'b1;
      mem_en = 1'b1;
      tick();
      chk("b2b_addr1", imem_addr, 16'h0002);
      chk("b2b_pc1", ifid_pc, 16'h0000);
      tick();
      chk("b2b_addr2", imem_addr, 16'h0004);
      chk("b2b_pc2", ifid_pc, 16'h0002);

      // Stall three cycles while 0x0004 returns
      stall = 1'b1;
      tick();
      chk("hold_req", {15'd0, imem_req}, 16'd0);
      chk("hold_pc", ifid_pc, 16'h0002);
      tick();
      tick();
      chk("hold_pc_late", ifid_pc, 16'h0002);
      chk("hold_valid", {15'd0, ifid_valid}, 16'd1);
      stall = 1'b0;
      tick();
      chk("release_pc", ifid_pc, 16'h0004);
      chk("release_instr", ifid_instr, 16'h4002);
      chk("resume_addr", imem_addr, 16'h0006);
      mem_en = 1'b0;

      // Redirect to 0x0010 while 0x0006 is outstanding, then 3-cycle memory
      tick();
      redirect    = 1'b1;
      redirect_pc = 16'h0010;
      tick();
      redirect = 1'b0;
      chk("drop1_addr", imem_addr, 16'h0006);
      chk("drop1_valid", {15'd0, ifid_valid}, 16'd0);
      lat    = 3;
      mem_en = 1'b1;
      tick();
      tick();
      chk("drop1_hold_addr", imem_addr, 16'h0006);
      tick();
      chk("req10_addr", imem_addr, 16'h0010);
      // Redirect on the first cycle of the 0x0010 request
      redirect    = 1'b1;
      redirect_pc = 16'h0100;
      tick();
      redirect = 1'b0;
      chk("drop2_addr_a", imem_addr, 16'h0010);
      tick();
      chk("drop2_addr_b", imem_addr, 16'h0010);
      chk("drop2_valid", {15'd0, ifid_valid}, 16'd0);
      tick();
      chk("req100_addr", imem_addr, 16'h0100);
      chk("req100_valid", {15'd0, ifid_valid}, 16'd0);
      push(16'h4080, 16'h0100);
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         tick();
         if (ifid_valid) seen = 1'b1;
      end
      chk("req100_arrived", {15'd0, seen}, 16'd1);
      mem_en = 1'b0;

      // HALT at 0x0020
      tick();
      halt_en     = 1'b1;
      lat         = 1;
      redirect    = 1'b1;
      redirect_pc = 16'h0020;
      tick();
      redirect = 1'b0;
      mem_en   = 1'b1;
      tick();
      chk("req20_addr", imem_addr, 16'h0020);
      push(16'h0000, 16'h0020);
      tick();
      chk("halt_flag", {15'd0, halted}, 16'd1);
      chk("halt_req", {15'd0, imem_req}, 16'd0);
      chk("halt_valid", {15'd0, ifid_valid}, 16'd1);
      chk("halt_instr", ifid_instr, 16'h0000);
      tick();
      tick();
      chk("halt_stay", {15'd0, halted}, 16'd1);
      chk("halt_stay_req", {15'd0, imem_req}, 16'd0);
      redirect    = 1'b1;
      redirect_pc = 16'h0040;
      tick();
      redirect = 1'b0;
      chk("unhalt_flag", {15'd0, halted}, 16'd0);
      chk("unhalt_addr", imem_addr, 16'h0040);

      // Redirect and stall together with a valid IF/ID entry
      stall = 1'b1;
      tick();
      chk("rs_pre_valid", {15'd0, ifid_valid}, 16'd1);
      chk("rs_pre_pc", ifid_pc, 16'h0040);
      redirect    = 1'b1;
      redirect_pc = 16'hFFFE;
      tick();
      redirect = 1'b0;
      stall    = 1'b0;
      chk("rs_valid", {15'd0, ifid_valid}, 16'd0);
      chk("rs_instr", ifid_instr, 16'h0800);
      chk("wrap_req_addr", imem_addr, 16'hFFFE);

      // PC wrap at 0xFFFE
      push(16'h4800, 16'hFFFE);
      tick();
      chk("wrap_pc", ifid_pc, 16'hFFFE);
      chk("wrap_pc_plus2", ifid_pc_plus2, 16'h0000);
      chk("wrap_next_addr", imem_addr, 16'h0000);

      // Reset pulsed mid-request
      lat = 3;
      tick();
      tick();
      tick();
      chk("pre_rst_instr", ifid_instr, 16'h4000);
      chk("pre_rst_addr", imem_addr, 16'h0002);
      #2;
      rst_n  = 1'b0;
      mem_en = 1'b0;
      #1;
      check_reset_vals("async_rst");
      tick();
      rst_n = 1'b1;
      tick();
      tick();

      chk("sb_leftover", exp_q.size()[15:0], 16'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
